// File: rtl/shake256_squeeze_if.sv
// shake256_squeeze_if: command, output-lane stream and permutation-core signals of the squeeze block
interface shake256_squeeze_if #(
  parameter int LANE_W = 64
);
  // command side: capture state and requested lane count on start
  logic              start;
  logic [1599:0]     state_in;
  logic [15:0]       out_len;
  // output lane stream (valid/ready)
  logic [LANE_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  // external Keccak-f core
  logic              perm_start;
  logic [1599:0]     perm_state_o;
  logic [1599:0]     perm_state_i;
  logic              perm_done;
  // status
  logic              busy;
  logic              done;

  // slave: the squeeze block itself
  modport slave (
    input  start, state_in, out_len, dout_ready, perm_state_i, perm_done,
    output dout, dout_valid, dout_last, perm_start, perm_state_o, busy, done
  );

  // master: requester, lane consumer and permutation core around the block
  modport master (
    output start, state_in, out_len, dout_ready, perm_state_i, perm_done,
    input  dout, dout_valid, dout_last, perm_start, perm_state_o, busy, done
  );
endinterface

// File: rtl/shake256_squeeze.sv
// shake256_squeeze: streams SHAKE256 output lanes from a permuted state, re-permuting between rate blocks
module shake256_squeeze #(
  parameter int RATE_LANES = 17,
  parameter int LANE_W     = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  shake256_squeeze_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EMIT, PERM, FIN} state_t;

  localparam logic [4:0] LAST_IDX = 5'(RATE_LANES - 1);

  state_t            state_q;
  logic [1599:0]     held_q;
  logic [15:0]       rem_q;
  logic [4:0]        idx_q;
  logic [LANE_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              dout_last_q;
  logic              perm_start_q;
  logic [1599:0]     perm_state_q;
  logic              busy_q;
  logic              done_q;

  // lane k sits at the top of the state vector first, moving down LANE_W bits per lane
  function automatic logic [LANE_W-1:0] lane(input logic [1599:0] s, input logic [4:0] k);
    return s[1599 - LANE_W * int'(k) -: LANE_W];
  endfunction

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.dout_last    = dout_last_q;
  assign bus.perm_start   = perm_start_q;
  assign bus.perm_state_o = perm_state_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // squeeze sequencer: all outputs are registered and loaded one cycle ahead of the state they belong to
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      held_q       <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      perm_start_q <= 1'b0;
      perm_state_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      perm_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (bus.out_len == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              held_q       <= bus.state_in;
              rem_q        <= bus.out_len;
              idx_q        <= 5'd0;
              dout_q       <= lane(bus.state_in, 5'd0);
              dout_valid_q <= 1'b1;
              dout_last_q  <= (bus.out_len == 16'd1);
              busy_q       <= 1'b1;
              state_q      <= EMIT;
            end
          end
        end
        EMIT: begin
          if (bus.dout_ready) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= FIN;
            end else if (idx_q == LAST_IDX) begin
              idx_q        <= 5'd0;
              dout_valid_q <= 1'b0;
              dout_last_q  <= 1'b0;
              perm_start_q <= 1'b1;
              perm_state_q <= held_q;
              state_q      <= PERM;
            end else begin
              idx_q       <= idx_q + 5'd1;
              dout_q      <= lane(held_q, idx_q + 5'd1);
              dout_last_q <= (rem_q == 16'd2);
            end
          end
        end
        PERM: begin
          if (bus.perm_done) begin
            held_q       <= bus.perm_state_i;
            dout_q       <= lane(bus.perm_state_i, 5'd0);
            dout_valid_q <= 1'b1;
            dout_last_q  <= (rem_q == 16'd1);
            state_q      <= EMIT;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shake256_squeeze.sv
// tb_shake256_squeeze: randomized scenarios checked against a block/lane reference model
module tb_shake256_squeeze;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  shake256_squeeze_if #(.LANE_W(64)) bus ();
  shake256_squeeze dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;

  logic [63:0]   beats[$];
  bit            lasts[$];
  int            bcyc[$];
  logic [1599:0] sts[$];
  logic [1599:0] seen[$];
  int perms, dones, stall_err, busy_err, vld_err, done_cyc, last_ps, cur_len;
  bit timeout;
  logic post_done, post_busy;

  function automatic logic [1599:0] rand1600();
    logic [1599:0] r = '0;
    for (int i = 0; i < 50; i++) r = {r[1567:0], 32'($urandom)};
    return r;
  endfunction

  // lane k is the k-th 64-bit group counted from the most significant end
  function automatic logic [63:0] lane_of(input logic [1599:0] s, input int k);
    logic [1599:0] t = s >> (1600 - 64 * (k + 1));
    return t[63:0];
  endfunction

  // output lane j comes from rate block j/17 (block 0 = start state, block b = b-th core result)
  function automatic int lane_errs();
    int e = 0;
    for (int j = 0; j < beats.size(); j++) begin
      if (j / 17 >= sts.size()) e++;
      else if (beats[j] !== lane_of(sts[j / 17], j % 17) || lasts[j] !== (j == cur_len - 1)) e++;
    end
    return e;
  endfunction

  function automatic int perm_errs();
    int e = 0;
    for (int b = 0; b < seen.size(); b++)
      if (b >= sts.size() || seen[b] !== sts[b]) e++;
    return e;
  endfunction

  // drives one squeeze request, plays consumer and permutation core, records what the DUT does
  task automatic run_squeeze(input logic [15:0] len, input logic [1599:0] sin, input bit rnd_ready,
                             input int dly, input bit noise, input bit rel);
    int cyc = 0;
    int ps_cyc = 0;
    bit pend = 0;
    bit pv = 0;
    bit pr = 1;
    bit pl = 0;
    logic [63:0] pd = '0;
    logic [1599:0] pnew = '0;
    beats.delete(); lasts.delete(); bcyc.delete(); sts.delete(); seen.delete();
    sts.push_back(sin);
    perms = 0; dones = 0; stall_err = 0; busy_err = 0; vld_err = 0;
    done_cyc = -1; last_ps = -1; timeout = 0; cur_len = int'(len);
    @(negedge clk);
    if (rel) rst_n = 1'b1;
    bus.start = 1'b1; bus.state_in = sin; bus.out_len = len; bus.dout_ready = 1'b1; bus.perm_done = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (pv && !pr && (!bus.dout_valid || bus.dout !== pd || bus.dout_last !== pl)) stall_err++;
      if (bus.busy !== (len != 16'd0)) busy_err++;
      if (len == 16'd0 && bus.dout_valid) vld_err++;
      if (bus.perm_start) begin
        perms++; seen.push_back(bus.perm_state_o); ps_cyc = cyc; last_ps = cyc; pend = 1; pnew = rand1600();
      end
      if (pend && bus.perm_state_o !== seen[$]) stall_err++;
      if (bus.done) begin dones++; done_cyc = cyc; break; end
      if (cyc > 3000) begin timeout = 1; break; end
      bus.dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.dout_valid && bus.dout_ready) begin
        beats.push_back(bus.dout); lasts.push_back(bus.dout_last); bcyc.push_back(cyc);
      end
      pv = bus.dout_valid; pr = bus.dout_ready; pd = bus.dout; pl = bus.dout_last;
      bus.start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.out_len  = noise ? 16'($urandom) : len;
      bus.state_in = noise ? rand1600() : sin;
      if (pend && cyc == ps_cyc + dly) begin
        bus.perm_done = 1'b1; bus.perm_state_i = pnew; sts.push_back(pnew); pend = 0;
      end else begin
        bus.perm_done = noise && !pend && $urandom_range(0, 3) == 0;
        bus.perm_state_i = noise ? rand1600() : '0;
      end
    end
    bus.start = 1'b0; bus.perm_done = 1'b0; bus.dout_ready = 1'b1;
    @(negedge clk);
    post_done = bus.done; post_busy = bus.busy;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if ({bus.dout, bus.dout_valid, bus.dout_last} !== '0) begin failures++; $display("FAIL reset_stream got=%0h exp=0", {bus.dout, bus.dout_valid, bus.dout_last}); end
    checks++; if ({bus.busy, bus.done, bus.perm_start} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=000", {bus.busy, bus.done, bus.perm_start}); end
    checks++; if (bus.perm_state_o !== '0) begin failures++; $display("FAIL reset_perm_state got=%0h exp=0", bus.perm_state_o); end
  endtask

  task automatic test_empty_msg();
    logic [1599:0] s = rand1600();
    s[1599:1536] = 64'h46b9dd2b0ba88d13;
    run_squeeze(16'd1, s, 1'b0, 0, 1'b0, 1'b1);
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL len1_timeout got=%0d exp=0", timeout); end
    checks++; if (beats.size() !== 1) begin failures++; $display("FAIL len1_beats got=%0d exp=1", beats.size()); end
    checks++; if ((bcyc.size() ? bcyc[0] : -1) !== 1) begin failures++; $display("FAIL first_start_after_reset beat_cycle got=%0d exp=1", bcyc.size() ? bcyc[0] : -1); end
    checks++; if (lane_errs() !== 0) begin failures++; $display("FAIL len1_lanes errs got=%0d exp=0", lane_errs()); end
    checks++; if ((beats.size() ? beats[0] : 64'h0) !== 64'h46b9dd2b0ba88d13) begin failures++; $display("FAIL len1_lane0 got=%0h exp=46b9dd2b0ba88d13", beats.size() ? beats[0] : 64'h0); end
    checks++; if (done_cyc !== (bcyc.size() ? bcyc[0] + 1 : -2)) begin failures++; $display("FAIL len1_done_cycle got=%0d exp=beat+1", done_cyc); end
    checks++; if (perms !== 0) begin failures++; $display("FAIL len1_perm_starts got=%0d exp=0", perms); end
    checks++; if ({post_done, post_busy} !== 2'b00) begin failures++; $display("FAIL len1_after_done got=%b exp=00", {post_done, post_busy}); end
  endtask

  task automatic test_full_block();
    run_squeeze(16'd17, rand1600(), 1'b0, 0, 1'b0, 1'b0);
    checks++; if (beats.size() !== 17) begin failures++; $display("FAIL len17_beats got=%0d exp=17", beats.size()); end
    checks++; if ((bcyc.size() == 17 ? bcyc[16] - bcyc[0] : -1) !== 16) begin failures++; $display("FAIL len17_consecutive span got=%0d exp=16", bcyc.size() == 17 ? bcyc[16] - bcyc[0] : -1); end
    checks++; if (lane_errs() !== 0) begin failures++; $display("FAIL len17_lanes errs got=%0d exp=0", lane_errs()); end
    checks++; if (perms !== 0) begin failures++; $display("FAIL len17_perm_starts got=%0d exp=0", perms); end
  endtask

  task automatic test_one_perm();
    run_squeeze(16'd18, rand1600(), 1'b0, 24, 1'b0, 1'b0);
    checks++; if (beats.size() !== 18) begin failures++; $display("FAIL len18_beats got=%0d exp=18", beats.size()); end
    checks++; if (perms !== 1) begin failures++; $display("FAIL len18_perm_starts got=%0d exp=1", perms); end
    checks++; if (perm_errs() !== 0) begin failures++; $display("FAIL len18_perm_state errs got=%0d exp=0", perm_errs()); end
    checks++; if (last_ps !== (bcyc.size() > 16 ? bcyc[16] + 1 : -2)) begin failures++; $display("FAIL len18_perm_start_cycle got=%0d exp=beat16+1", last_ps); end
    checks++; if ((bcyc.size() == 18 ? bcyc[17] : -1) !== last_ps + 25) begin failures++; $display("FAIL len18_resume_cycle got=%0d exp=%0d", bcyc.size() == 18 ? bcyc[17] : -1, last_ps + 25); end
    checks++; if (lane_errs() !== 0) begin failures++; $display("FAIL len18_lanes errs got=%0d exp=0", lane_errs()); end
    checks++; if (stall_err !== 0) begin failures++; $display("FAIL len18_perm_state_stable errs got=%0d exp=0", stall_err); end
  endtask

  task automatic test_stall();
    for (int it = 0; it < 3; it++) begin
      run_squeeze(16'd5, rand1600(), 1'b1, 0, 1'b0, 1'b0);
      checks++; if (beats.size() !== 5) begin failures++; $display("FAIL stall_beats it=%0d got=%0d exp=5", it, beats.size()); end
      checks++; if (lane_errs() !== 0) begin failures++; $display("FAIL stall_lanes it=%0d errs got=%0d exp=0", it, lane_errs()); end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL stall_hold it=%0d errs got=%0d exp=0", it, stall_err); end
    end
  endtask

  task automatic test_len0();
    run_squeeze(16'd0, rand1600(), 1'b0, 0, 1'b0, 1'b0);
    checks++; if (done_cyc !== 1) begin failures++; $display("FAIL len0_done_cycle got=%0d exp=1", done_cyc); end
    checks++; if (vld_err + beats.size() !== 0) begin failures++; $display("FAIL len0_no_valid got=%0d exp=0", vld_err + beats.size()); end
    checks++; if (busy_err !== 0) begin failures++; $display("FAIL len0_busy errs got=%0d exp=0", busy_err); end
    checks++; if ({post_done, post_busy, perms[0]} !== 3'b000) begin failures++; $display("FAIL len0_after got=%b exp=000", {post_done, post_busy, perms[0]}); end
  endtask

  task automatic test_random_lengths();
    for (int it = 0; it < 6; it++) begin
      int len = $urandom_range(1, 60);
      run_squeeze(16'(len), rand1600(), 1'b1, $urandom_range(0, 6), 1'b1, 1'b0);
      checks++; if (beats.size() !== len) begin failures++; $display("FAIL rnd_beats len=%0d got=%0d exp=%0d", len, beats.size(), len); end
      checks++; if (perms !== (len + 16) / 17 - 1) begin failures++; $display("FAIL rnd_perm_count len=%0d got=%0d exp=%0d", len, perms, (len + 16) / 17 - 1); end
      checks++; if (lane_errs() + perm_errs() !== 0) begin failures++; $display("FAIL rnd_lanes len=%0d errs got=%0d exp=0", len, lane_errs() + perm_errs()); end
      checks++; if (stall_err + busy_err !== 0) begin failures++; $display("FAIL rnd_hold_busy len=%0d errs got=%0d exp=0", len, stall_err + busy_err); end
      checks++; if ({dones[0], post_done, timeout} !== 3'b100) begin failures++; $display("FAIL rnd_done len=%0d got=%b exp=100", len, {dones[0], post_done, timeout}); end
    end
  endtask

  task automatic test_reset_mid_perm();
    int n = 0;
    int bad = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.out_len = 16'd40; bus.state_in = rand1600(); bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.perm_start && n < 100) begin @(negedge clk); n++; end
    checks++; if (n >= 100) begin failures++; $display("FAIL rst_wait_perm got=%0d cycles exp=<100", n); end
    repeat (3) @(negedge clk);
    checks++; if ({bus.busy, bus.dout_valid} !== 2'b10) begin failures++; $display("FAIL rst_in_perm got=%b exp=10", {bus.busy, bus.dout_valid}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.dout, bus.dout_valid, bus.dout_last} !== '0) begin failures++; $display("FAIL rst_mid_stream got=%0h exp=0", {bus.dout, bus.dout_valid, bus.dout_last}); end
    checks++; if ({bus.busy, bus.done, bus.perm_start} !== 3'b000) begin failures++; $display("FAIL rst_mid_status got=%b exp=000", {bus.busy, bus.done, bus.perm_start}); end
    checks++; if (bus.perm_state_o !== '0) begin failures++; $display("FAIL rst_mid_perm_state got=%0h exp=0", bus.perm_state_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; bus.perm_done = 1'b1; bus.perm_state_i = rand1600();
    @(negedge clk);
    bus.perm_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ({bus.dout_valid, bus.busy, bus.perm_start, bus.done} !== 4'b0000 || bus.perm_state_o !== '0) bad++;
      @(negedge clk);
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rst_late_perm_done cycles_active got=%0d exp=0", bad); end
    run_squeeze(16'd2, rand1600(), 1'b0, 0, 1'b0, 1'b0);
    checks++; if (beats.size() !== 2) begin failures++; $display("FAIL rst_restart_beats got=%0d exp=2", beats.size()); end
    checks++; if (lane_errs() + perms !== 0) begin failures++; $display("FAIL rst_restart_lanes errs got=%0d exp=0", lane_errs() + perms); end
  endtask

  initial begin
    bus.start = 1'b0; bus.state_in = '0; bus.out_len = '0;
    bus.dout_ready = 1'b0; bus.perm_state_i = '0; bus.perm_done = 1'b0;
    test_reset();
    test_empty_msg();
    test_full_block();
    test_one_perm();
    test_stall();
    test_len0();
    test_random_lengths();
    test_reset_mid_perm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shake256_squeeze.md
SHAKE256_SQUEEZE -- requirements
Module: shake256_squeeze

Interface
REQ-001 Parameters: RATE_LANES, default 17, lanes per rate block (1088 bits); LANE_W, default 64, output lane width.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a squeeze; sampled only in IDLE.
REQ-005 state_in  input  1600  post-absorb, already-permuted Keccak state; captured on accepted start.
REQ-006 out_len  input  16  number of output lanes requested; captured on accepted start.
REQ-007 dout  output  64  current output lane.
REQ-008 dout_valid  output  1  dout holds a valid lane.
REQ-009 dout_ready  input  1  consumer accepts dout this cycle.
REQ-010 dout_last  output  1  high with dout_valid on the final requested lane.
REQ-011 perm_start  output  1  one-cycle pulse requesting a Keccak-f permutation of perm_state_o.
REQ-012 perm_state_o  output  1600  state handed to the permutation core.
REQ-013 perm_state_i  input  1600  permuted state returned by the core.
REQ-014 perm_done  input  1  perm_state_i valid this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on squeeze completion.

Function
REQ-017 Lane k (0..RATE_LANES-1) of the held state SHALL be bits [1599-64k : 1536-64k]; lanes emitted in increasing k.
REQ-018 FSM states: IDLE, EMIT, PERM, FIN.
REQ-019 IDLE, start=1, out_len!=0: capture state_in and out_len; lane_idx=0; go to EMIT; dout_valid high the next cycle.
REQ-020 IDLE, start=1, out_len=0: pulse done for one cycle with no dout_valid and no perm_start; remain in IDLE.
REQ-021 EMIT: dout_valid=1; dout = lane lane_idx of the held state.
REQ-022 A beat completes only when dout_valid and dout_ready are both high; dout, dout_last, and dout_valid SHALL hold stable while dout_ready is low.
REQ-023 On a beat, remaining decrements and lane_idx increments.
REQ-024 dout_last=1 exactly when remaining=1 in EMIT.
REQ-025 On a beat with dout_last=1: go to FIN; the held state is unused afterwards.
REQ-026 On a non-last beat with lane_idx=RATE_LANES-1: lane_idx wraps to 0; go to PERM.
REQ-027 Entering PERM: perm_start is high for exactly the first PERM cycle; perm_state_o = held state, stable throughout PERM.
REQ-028 PERM: dout_valid=0; perm_done is accepted on any PERM cycle, including the first; on acceptance, latch perm_state_i into the held state and go to EMIT; dout_valid is high the next cycle.
REQ-029 perm_done outside PERM SHALL be ignored.
REQ-030 FIN: done=1 for one cycle; then IDLE.
REQ-031 start while busy SHALL be ignored, with no effect on captured out_len or state.
REQ-032 Permutations per squeeze SHALL equal ceil(out_len/RATE_LANES)-1; no permutation after the final lane.
REQ-033 out_len=65535 SHALL complete without counter overflow; remaining is 16 bits and lane_idx is 5 bits.

Reset
REQ-034 Reset low, at any time including mid-EMIT or mid-PERM:
- FSM to IDLE.
- dout, dout_valid, dout_last, perm_start, busy, done, perm_state_o, held state, counters all 0.
- A perm_done arriving after reset release with no PERM entry is ignored.
REQ-035 The first start SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-036 Absorb of empty message (state_in = first permutation of 0x1F...80 padded block), out_len=1, dout_ready=1 -> one beat, dout_last=1, done one cycle later, perm_start never asserted.
REQ-037 out_len=17, dout_ready=1 -> 17 consecutive beats, lanes 0..16 in order, last beat flagged, zero perm_start pulses.
REQ-038 out_len=18, model core returns perm_done 24 cycles after perm_start -> 17 beats, one perm_start carrying held state, 24-cycle gap, 18th beat = lane 0 of perm_state_i with dout_last=1.
REQ-039 out_len=5, dout_ready toggled pseudo-randomly -> exactly 5 accepted beats, dout stable across stalls, no duplicated or skipped lanes.
REQ-040 out_len=0 -> done pulse next cycle, no dout_valid; busy stays 0.
REQ-041 Reset asserted in PERM during out_len=40, then perm_done pulsed -> outputs all 0, FSM in IDLE, late perm_done ignored; a new start with out_len=2 works normally.
